// File: rtl/motion_profile_seq.sv
// motion_profile_seq: queued x/v/a/j segment integrator with step/dir pulse generation.
module motion_profile_seq #(
  parameter int XW       = 64,
  parameter int VW       = 32,
  parameter int AW       = 32,
  parameter int JW       = 32,
  parameter int DW       = 32,
  parameter int DEPTH    = 4,
  parameter int STEP_LEN = 4,
  parameter int SBW      = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     acc_step,
  input  logic                     seg_valid,
  output logic                     seg_ready,
  input  logic                     seg_set_v,
  input  logic                     seg_set_a,
  input  logic                     seg_set_j,
  input  logic [VW-1:0]            seg_v,
  input  logic [AW-1:0]            seg_a,
  input  logic [JW-1:0]            seg_j,
  input  logic [DW-1:0]            seg_dur,
  input  logic                     set_x,
  input  logic [XW-1:0]            x_val,
  input  logic [SBW-1:0]           step_bit,
  input  logic                     abort,
  output logic [XW-1:0]            x,
  output logic [VW-1:0]            v,
  output logic [AW-1:0]            a,
  output logic [JW-1:0]            j,
  output logic                     step,
  output logic                     dir,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   seg_count,
  output logic                     underrun,
  output logic                     step_err
);
  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 3 + VW + AW + JW + DW;
  localparam int SW = $clog2(STEP_LEN + 1);
  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          state_q, state_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [XW-1:0] x_q, x_d, x_int;
  logic [VW-1:0] v_q, v_d, v_int;
  logic [AW-1:0] a_q, a_d, a_int;
  logic [JW-1:0] j_q, j_d;
  logic [SW-1:0] pc_q, pc_d;
  logic          dir_q, dir_d, underrun_q, underrun_d, step_err_q, step_err_d;
  logic          h_sv, h_sa, h_sj;
  logic [VW-1:0] h_v;
  logic [AW-1:0] h_a;
  logic [JW-1:0] h_j;
  logic [DW-1:0] h_dur;
  logic          push, pop, seg_end, ev;
  assign {h_sv, h_sa, h_sj, h_v, h_a, h_j, h_dur} = mem_q[rd_q];
  assign seg_ready = cnt_q < CW'(DEPTH);
  assign push      = seg_valid && seg_ready;
  assign v_int     = acc_step ? v_q + VW'($signed(a_q)) : v_q;
  assign a_int     = acc_step ? a_q + AW'($signed(j_q)) : a_q;
  assign seg_end   = state_q == RUN && acc_step && rem_q == DW'(1);
  assign pop       = !abort && cnt_q != '0 && (state_q == IDLE || seg_end);
  assign x_int     = x_q + XW'($signed(v_q));
  assign ev        = !set_x && (x_q[step_bit] != x_int[step_bit]);
  always_comb begin
    wr_d       = push ? wr_q + PW'(1) : wr_q;
    rd_d       = pop ? rd_q + PW'(1) : rd_q;
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    state_d    = state_q;
    rem_d      = (state_q == RUN && acc_step) ? rem_q - DW'(1) : rem_q;
    v_d        = v_int;
    a_d        = a_int;
    j_d        = j_q;
    underrun_d = underrun_q;
    if (pop) begin
      v_d     = h_sv ? h_v : v_int;
      a_d     = h_sa ? h_a : a_int;
      j_d     = h_sj ? h_j : j_q;
      rem_d   = h_dur;
      state_d = h_dur == '0 ? IDLE : RUN;
    end else if (seg_end) begin
      a_d        = '0;
      j_d        = '0;
      underrun_d = 1'b1;
      state_d    = IDLE;
    end
    // abort wins over any push, pop or integration in the same cycle
    if (abort) begin
      wr_d       = '0;
      rd_d       = '0;
      cnt_d      = '0;
      state_d    = IDLE;
      rem_d      = '0;
      v_d        = '0;
      a_d        = '0;
      j_d        = '0;
      underrun_d = 1'b0;
    end
  end
  always_comb begin
    x_d        = set_x ? x_val : x_int;
    pc_d       = (ev && pc_q == '0) ? SW'(STEP_LEN) : (pc_q != '0 ? pc_q - SW'(1) : '0);
    dir_d      = (ev && pc_q == '0) ? (!v_q[VW-1] && v_q != '0) : dir_q;
    step_err_d = abort ? 1'b0 : (step_err_q || (ev && pc_q != '0));
  end
  always_ff @(posedge clk)
    if (push && !abort) mem_q[wr_q] <= {seg_set_v, seg_set_a, seg_set_j, seg_v, seg_a, seg_j, seg_dur};
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      state_q    <= IDLE;
      rem_q      <= '0;
      x_q        <= '0;
      v_q        <= '0;
      a_q        <= '0;
      j_q        <= '0;
      pc_q       <= '0;
      dir_q      <= 1'b0;
      underrun_q <= 1'b0;
      step_err_q <= 1'b0;
    end else begin
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      rem_q      <= rem_d;
      x_q        <= x_d;
      v_q        <= v_d;
      a_q        <= a_d;
      j_q        <= j_d;
      pc_q       <= pc_d;
      dir_q      <= dir_d;
      underrun_q <= underrun_d;
      step_err_q <= step_err_d;
    end
  end
  assign x         = x_q;
  assign v         = v_q;
  assign a         = a_q;
  assign j         = j_q;
  assign step      = pc_q != '0;
  assign dir       = dir_q;
  assign busy      = state_q == RUN;
  assign seg_count = cnt_q;
  assign underrun  = underrun_q;
  assign step_err  = step_err_q;
endmodule

// File: tb/tb_motion_profile_seq.sv
// tb_motion_profile_seq: directed test-plan scenarios plus random traffic against a queue-based model.
module tb_motion_profile_seq;
  localparam int XW = 64, VW = 32, AW = 32, JW = 32, DW = 32, DEPTH = 4, STEP_LEN = 4, SBW = 6;
  logic clk = 0, reset = 1, acc_step = 0, seg_valid = 0, seg_set_v = 0, seg_set_a = 0, seg_set_j = 0;
  logic [VW-1:0] seg_v = 0;
  logic [AW-1:0] seg_a = 0;
  logic [JW-1:0] seg_j = 0;
  logic [DW-1:0] seg_dur = 0;
  logic set_x = 0, abort = 0;
  logic [XW-1:0] x_val = 0;
  logic [SBW-1:0] step_bit = 6'd4;
  logic [XW-1:0] x;
  logic [VW-1:0] v;
  logic [AW-1:0] a;
  logic [JW-1:0] j;
  logic step, dir, busy, seg_ready, underrun, step_err;
  logic [$clog2(DEPTH):0] seg_count;
  motion_profile_seq #(.XW(XW), .VW(VW), .AW(AW), .JW(JW), .DW(DW), .DEPTH(DEPTH),
                       .STEP_LEN(STEP_LEN), .SBW(SBW)) dut (
    .clk(clk), .reset(reset), .acc_step(acc_step), .seg_valid(seg_valid), .seg_ready(seg_ready),
    .seg_set_v(seg_set_v), .seg_set_a(seg_set_a), .seg_set_j(seg_set_j), .seg_v(seg_v),
    .seg_a(seg_a), .seg_j(seg_j), .seg_dur(seg_dur), .set_x(set_x), .x_val(x_val),
    .step_bit(step_bit), .abort(abort), .x(x), .v(v), .a(a), .j(j), .step(step), .dir(dir),
    .busy(busy), .seg_count(seg_count), .underrun(underrun), .step_err(step_err));
  always #5 clk = ~clk;
  typedef struct {bit sv, sa, sj; int v, a, j; int unsigned dur;} seg_t;
  seg_t mq[$];
  longint mx;
  int mv, ma, mj, pl;
  int unsigned mrem;
  bit mbusy, munder, merr, mdir;
  int total = 0, bad = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_step();
    longint nx;
    int nv, na, nj, npl;
    bit ev, ending, can_push;
    seg_t s;
    if (reset) begin
      mx = 0; mv = 0; ma = 0; mj = 0; mq.delete(); mbusy = 0; mrem = 0;
      munder = 0; merr = 0; mdir = 0; pl = 0;
      return;
    end
    can_push = seg_valid && mq.size() < DEPTH;
    nx = set_x ? longint'(x_val) : mx + longint'(mv);
    ev = !set_x && (mx[step_bit] != nx[step_bit]);
    npl = pl > 0 ? pl - 1 : 0;
    if (ev && pl == 0) begin npl = STEP_LEN; mdir = mv > 0; end
    else if (ev) merr = 1;
    nv = acc_step ? mv + ma : mv;
    na = acc_step ? ma + mj : ma;
    nj = mj;
    if (abort) begin
      mq.delete(); nv = 0; na = 0; nj = 0; mbusy = 0; mrem = 0; munder = 0; merr = 0;
    end else begin
      ending = mbusy && acc_step && mrem == 1;
      if (mbusy && acc_step) mrem--;
      if ((!mbusy || ending) && mq.size() > 0) begin
        s = mq.pop_front();
        if (s.sv) nv = s.v;
        if (s.sa) na = s.a;
        if (s.sj) nj = s.j;
        mrem = s.dur;
        mbusy = s.dur != 0;
      end else if (ending) begin
        na = 0; nj = 0; munder = 1; mbusy = 0;
      end
      if (can_push) begin
        s.sv = seg_set_v; s.sa = seg_set_a; s.sj = seg_set_j;
        s.v = int'(seg_v); s.a = int'(seg_a); s.j = int'(seg_j); s.dur = seg_dur;
        mq.push_back(s);
      end
    end
    mx = nx; mv = nv; ma = na; mj = nj; pl = npl;
  endtask
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("x", x, mx);
    chk("v", v, $unsigned(mv));
    chk("a", a, $unsigned(ma));
    chk("j", j, $unsigned(mj));
    chk("step", step, pl > 0);
    chk("dir", dir, mdir);
    chk("busy", busy, mbusy);
    chk("seg_count", seg_count, mq.size());
    chk("seg_ready", seg_ready, mq.size() < DEPTH);
    chk("underrun", underrun, munder);
    chk("step_err", step_err, merr);
  endtask
  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask
  task automatic push_seg(input bit sv, input bit sa, input bit sj, input int pv, input int pa,
                          input int pj, input int unsigned pd);
    bit ok;
    ok = 0;
    seg_valid = 1; seg_set_v = sv; seg_set_a = sa; seg_set_j = sj;
    seg_v = pv; seg_a = pa; seg_j = pj; seg_dur = pd;
    for (int k = 0; k < 100 && !ok; k++) begin
      ok = mq.size() < DEPTH;
      cyc();
    end
    seg_valid = 0;
    chk("push_accepted", ok, 1);
  endtask
  task automatic tick(input int idle);
    cycles(idle);
    acc_step = 1;
    cyc();
    acc_step = 0;
  endtask
  task automatic do_abort();
    abort = 1;
    cyc();
    abort = 0;
  endtask
  int hi;
  longint xs;
  initial begin
    cycles(2);
    reset = 0;
    cyc();
    chk("rst_busy", busy, 0);
    chk("rst_ready", seg_ready, 1);
    chk("rst_count", seg_count, 0);
    chk("rst_x", x, 0);
    // single segment then underrun
    push_seg(1, 1, 0, 0, 2, 0, 3);
    for (int k = 0; k < 3; k++) tick(3);
    cycles(2);
    chk("t1_v", v, 6);
    chk("t1_a", a, 0);
    chk("t1_under", underrun, 1);
    chk("t1_busy", busy, 0);
    // back-to-back chaining
    do_abort();
    push_seg(0, 1, 0, 0, 1, 0, 2);
    push_seg(0, 1, 0, 0, -1, 0, 2);
    tick(2);
    chk("t2_v1", v, 1);
    tick(2);
    chk("t2_v2", v, 2);
    chk("t2_busy_mid", busy, 1);
    chk("t2_under_mid", underrun, 0);
    tick(2);
    chk("t2_v3", v, 1);
    tick(2);
    chk("t2_v4", v, 0);
    chk("t2_under_end", underrun, 1);
    // step pulses
    do_abort();
    set_x = 1; x_val = 0; cyc(); set_x = 0;
    step_bit = 4;
    push_seg(1, 1, 1, 2, 0, 0, 0);
    cycles(20);
    hi = 0;
    for (int k = 0; k < 32; k++) begin cyc(); hi += step; end
    chk("t3_duty", hi, 16);
    chk("t3_dir_pos", dir, 1);
    chk("t3_err0", step_err, 0);
    push_seg(1, 0, 0, -2, 0, 0, 0);
    cycles(40);
    chk("t3_dir_neg", dir, 0);
    push_seg(1, 0, 0, 16, 0, 0, 0);
    cycles(20);
    chk("t3_err", step_err, 1);
    // queue full back-pressure
    do_abort();
    push_seg(1, 1, 1, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) push_seg(1, 0, 0, k, 0, 0, 1);
    seg_valid = 1; seg_set_v = 1; seg_v = 9; seg_dur = 1;
    cycles(3);
    chk("t4_count", seg_count, 4);
    chk("t4_ready", seg_ready, 0);
    acc_step = 1; cyc(); acc_step = 0;
    cyc();
    seg_valid = 0;
    chk("t4_count2", seg_count, 4);
    // abort mid-run
    do_abort();
    push_seg(1, 1, 1, 100, 0, 0, 5);
    push_seg(0, 1, 0, 0, 1, 0, 2);
    push_seg(0, 1, 0, 0, 1, 0, 2);
    cyc();
    chk("t5_v_pre", v, 100);
    do_abort();
    chk("t5_v", v, 0);
    chk("t5_count", seg_count, 0);
    chk("t5_busy", busy, 0);
    xs = mx;
    cycles(5);
    chk("t5_x_hold", x, xs);
    // set_x and mid-operation reset
    cycles(10);
    set_x = 1; x_val = 15; cyc();
    x_val = 16; cyc(); set_x = 0;
    chk("t6_x", x, 16);
    cyc();
    chk("t6_nostep", step, 0);
    push_seg(1, 0, 0, 5, 0, 0, 0);
    cycles(3);
    reset = 1; cyc(); reset = 0;
    chk("t6_rst_x", x, 0);
    chk("t6_rst_v", v, 0);
    chk("t6_rst_step", step, 0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      reset = $urandom_range(0, 199) == 0;
      abort = $urandom_range(0, 99) == 0;
      acc_step = $urandom_range(0, 2) == 0;
      seg_valid = $urandom_range(0, 2) == 0;
      seg_set_v = 1'($urandom_range(0, 1));
      seg_set_a = 1'($urandom_range(0, 1));
      seg_set_j = 1'($urandom_range(0, 1));
      seg_v = $urandom_range(0, 40) - 20;
      seg_a = $urandom_range(0, 6) - 3;
      seg_j = $urandom_range(0, 2) - 1;
      seg_dur = $urandom_range(0, 4);
      set_x = $urandom_range(0, 49) == 0;
      x_val = {$urandom, $urandom};
      if ($urandom_range(0, 99) == 0) step_bit = 6'($urandom_range(0, 7));
      cyc();
    end
    reset = 0; abort = 0; acc_step = 0; seg_valid = 0; set_x = 0;
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/motion_profile_seq.md
Name: motion_profile_seq

Overview:
- Parametrised successor to the single-segment x/v/a/j integrator.
- Integrates jerk → acceleration → velocity on each acc_step tick, and position every clock.
- Adds a DEPTH-entry segment queue with per-segment durations and automatic back-to-back segment chaining.
- Adds stretched step pulses with overlap detection, and an underrun/abort policy.
- Sits between the motion command interface and one axis' step/dir output stage.

Parameters:
- XW, 64: position width.
- VW, 32: velocity width.
- AW, 32: acceleration width.
- JW, 32: jerk width. Widths must satisfy JW<=AW<=VW<=XW.
- DW, 32: segment duration width, counted in acc_step ticks.
- DEPTH, 4: segment queue depth. Must be a power of 2 and at least 2.
- STEP_LEN, 4: step pulse width in clk cycles. Must be at least 1.
- SBW, 6: width of step_bit. Must equal clog2(XW).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- acc_step  in  1  integration tick for v/a and segment duration
- seg_valid  in  1  segment push request
- seg_ready  out  1  queue not full
- seg_set_v, seg_set_a, seg_set_j  in  1 each  field-load mask for the segment
- seg_v  in  VW  segment velocity value
- seg_a  in  AW  segment acceleration value
- seg_j  in  JW  segment jerk value
- seg_dur  in  DW  segment length in acc_step ticks
- set_x  in  1  load position
- x_val  in  XW  position load value
- step_bit  in  SBW  position bit whose toggle generates a step
- abort  in  1  flush queue and stop motion
- x  out  XW  position
- v  out  VW  velocity
- a  out  AW  acceleration
- j  out  JW  jerk
- step  out  1  step pulse
- dir  out  1  direction, 1 = positive
- busy  out  1  segment active
- seg_count  out  clog2(DEPTH)+1  queue occupancy
- underrun  out  1  sticky: queue ran dry while running
- step_err  out  1  sticky: step event lost to an active pulse

Behaviour:
- Reset values:
  - x, v, a, j = 0; step = 0; dir = 0.
  - Queue empty, so seg_count = 0 and seg_ready = 1.
  - State IDLE; busy = 0; underrun = 0; step_err = 0.
- Queue push and occupancy:
  - seg_ready = (seg_count < DEPTH).
  - A push occurs when seg_valid && seg_ready; the entry is written at that clk edge.
  - A push and a pop in the same cycle leave seg_count unchanged.
- FSM state IDLE:
  - busy = 0.
  - If seg_count > 0, pop the head entry. For each set mask bit, load the field; fields without a mask bit keep their value. Load remaining = seg_dur and go to RUN.
  - A segment pushed into an empty queue is therefore applied 1 cycle after the push edge.
  - Any acc_step in IDLE still integrates: v += a, a += j.
- FSM state RUN:
  - busy = 1.
  - On acc_step: v += a, a += j, remaining -= 1. All updates are registered and visible the next cycle.
  - On the acc_step where remaining == 1, the segment ends. If the queue is non-empty, pop the next segment in that same cycle: masked fields take the new values and unmasked fields take the integrated result. remaining reloads and the FSM stays in RUN.
  - If the queue is empty at segment end: a and j are cleared to 0, v keeps its integrated value, underrun is set, and the FSM goes to IDLE.
- seg_dur = 0: the segment's values are applied and it ends immediately. The next pop is attempted on the following cycle, with no acc_step consumed. No underrun is flagged for this case.
- Arithmetic:
  - Two's complement with wrap-around and no saturation.
  - a is sign-extended to VW, j to AW, and v to XW.
- Position: every clock, x <= x + sext(v), using the registered v.
  - On set_x: x <= x_val, no step event is generated, and dir is unchanged.
  - set_x has priority over integration.
- Step events:
  - An event occurs when x[step_bit] != x_next[step_bit], where x_next is the integrated value (not a set_x load).
  - If an event arrives while the pulse counter is 0, it is accepted: dir <= (v > 0), and step is high for exactly STEP_LEN cycles starting the next cycle.
  - If an event arrives while a pulse is active, it is dropped: step_err is set and dir is not updated.
- abort (cycle it is asserted):
  - Queue flushed; v, a, j = 0; remaining = 0; state IDLE.
  - underrun and step_err cleared.
  - Any pulse in progress completes normally.
  - abort has priority over push, pop and acc_step in that cycle.
  - x keeps integrating with v = 0, so it holds.
- Mid-operation reset: every output returns to its reset value at the next edge, regardless of state.

Test Plan:
- Push {set_v v=0, set_a a=2, j=0, dur=3}; pulse acc_step every 4 clk → v = 2, 4, 6; then a = 0, v holds 6, underrun = 1, busy = 0.
- Push seg1 {set_a a=1, dur=2} and seg2 {set_a a=-1, dur=2} back-to-back → v = 1, 2, 1, 0; busy stays high throughout with no gap; underrun = 1 only after seg2 ends.
- step_bit = 4, STEP_LEN = 4, hold v = 2 → step high 4 cycles / low 4 cycles repeating, dir = 1. Then v = -2 → dir = 0. Then v = 16 → step_err = 1.
- DEPTH = 4, one segment running with no acc_step, push 5 segments → seg_count = 4, seg_ready = 0, 5th push held until an acc_step ends the active segment and pops one entry, then accepted.
- Mid-RUN abort with 2 entries queued and v = 100 → next cycle v = a = j = 0, seg_count = 0, busy = 0, x constant afterwards.
- x = 15, step_bit = 4, set_x with x_val = 16 → x = 16, no step. Then reset asserted while v = 5 → all outputs zero on the next edge.
